// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Memory-mapped 32-bit down-counting timer with one-shot / auto-reload modes
//   and a maskable interrupt request.
//
// Ports
//   clk     in   system clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset
//   addr    in   word address [31:2]; only addr[3:2] is decoded
//   we      in   write strobe for this device
//   byteen  in   byte enables, bit i covers din[8i+7:8i]
//   din     in   store data
//   dout    out  combinational read data for addr[3:2]
//   irq     out  interrupt request (irq_flag & CTRL.IM)
//
// Register map (addr[3:2])
//   0 CTRL   : bit0 EN, bits[2:1] MODE, bit3 IM (upper bits read 0)
//   1 PRESET : reload value
//   2 COUNT  : current count, read-only
//   3        : reserved, reads 0
// -----------------------------------------------------------------------------
module timer_counter #(
   parameter logic [31:0] PRESET_RST = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] addr,
   input  logic        we,
   input  logic [3:0]  byteen,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        irq
);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d, ctrl_fsm_s;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        irq_flag_q, irq_flag_d, irq_flag_fsm_s;
   logic        irq_q;
   logic [31:0] wmask_s;
   logic        ctrl_wr_s, preset_wr_s;

   // Upper address bits are decoded by the bridge, not here.
   logic unused_addr_s;
   assign unused_addr_s = ^addr[31:4];

   // Expand byte enables into a 32-bit bit mask.
   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
      end
      return m;
   endfunction

   assign wmask_s     = byte_mask(byteen);
   // A write with no byte lanes enabled is a no-op, including the irq_flag clear.
   assign ctrl_wr_s   = we && (addr[3:2] == ADDR_CTRL)   && (byteen != 4'd0);
   assign preset_wr_s = we && (addr[3:2] == ADDR_PRESET) && (byteen != 4'd0);

   // Timer sequencing: acts on the registered CTRL value only.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      ctrl_fsm_s     = ctrl_q;
      irq_flag_fsm_s = irq_flag_q;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_q[0]) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            count_d        = preset_q;
            irq_flag_fsm_s = 1'b0;
            state_d        = ST_CNT;
         end
         ST_CNT: begin
            if (!ctrl_q[0]) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               // 0 or 1 both expire here, so COUNT never wraps below zero.
               count_d        = 32'd0;
               irq_flag_fsm_s = 1'b1;
               state_d        = ST_INT;
            end
         end
         ST_INT: begin
            if (ctrl_q[2:1] == MODE_RELOAD) begin
               irq_flag_fsm_s = 1'b0;
            end else begin
               ctrl_fsm_s[0] = 1'b0;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Register writes merge bytewise and take priority over the FSM's EN clear.
   always_comb begin
      if (ctrl_wr_s) begin
         ctrl_d     = (ctrl_q & ~wmask_s[3:0]) | (din[3:0] & wmask_s[3:0]);
         irq_flag_d = 1'b0;
      end else begin
         ctrl_d     = ctrl_fsm_s;
         irq_flag_d = irq_flag_fsm_s;
      end
      if (preset_wr_s) begin
         preset_d = (preset_q & ~wmask_s) | (din & wmask_s);
      end else begin
         preset_d = preset_q;
      end
   end

   // State and register update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= PRESET_RST;
         count_q    <= 32'd0;
         irq_flag_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         irq_flag_q <= irq_flag_d;
         // Registered copy of irq_flag & IM, computed from the next-state values.
         irq_q      <= irq_flag_d & ctrl_d[3];
      end
   end

   // Zero-latency read-back mux.
   always_comb begin
      case (addr[3:2])
         ADDR_CTRL:   dout = {28'd0, ctrl_q};
         ADDR_PRESET: dout = preset_q;
         ADDR_COUNT:  dout = count_q;
         default:     dout = 32'd0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Scoreboard bench: each stimulus cycle pushes the model's expected read-back
//   and irq into a queue; a monitor on the falling edge pops and compares.
//   Directed sequences from the feature list are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_timer_counter;

   logic        clk = 1'b1;
   logic        reset;
   logic [31:2] addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   timer_counter #(.PRESET_RST(32'd0)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .din    (din),
      .dout   (dout),
      .irq    (irq)
   );

   typedef struct {
      bit          chk;
      logic [1:0]  a;
      logic [31:0] d;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   exp_t drv_e;
   exp_t mon_e;

   // Reference model: register contents plus the phase of the current activation.
   logic [3:0]  m_ctrl   = 4'd0;
   logic [31:0] m_preset = 32'd0;
   logic [31:0] m_count  = 32'd0;
   bit          m_flag   = 1'b0;
   bit          m_pend   = 1'b0;   // enable seen, reload happens next edge
   bit          m_run    = 1'b0;   // counting down
   bit          m_exp    = 1'b0;   // count just expired

   function automatic logic [31:0] replace_bytes(input logic [31:0] o, input logic [31:0] d,
                                                 input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic w, input logic [1:0] a,
                             input logic [3:0] be, input logic [31:0] d);
      logic [3:0]  oc;
      logic [31:0] op;
      logic [31:0] tmp;
      oc = m_ctrl;
      op = m_preset;
      if (r) begin
         m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
         m_flag = 1'b0; m_pend = 1'b0; m_run = 1'b0; m_exp = 1'b0;
      end else begin
         if (m_exp) begin
            m_exp = 1'b0;
            if (oc[2:1] == 2'd1) m_flag = 1'b0;
            else                 m_ctrl[0] = 1'b0;
         end else if (m_run) begin
            if (!oc[0]) m_run = 1'b0;
            else if (m_count > 32'd1) m_count = m_count - 32'd1;
            else begin
               m_count = 32'd0; m_flag = 1'b1; m_run = 1'b0; m_exp = 1'b1;
            end
         end else if (m_pend) begin
            m_count = op; m_flag = 1'b0; m_pend = 1'b0; m_run = 1'b1;
         end else if (oc[0]) begin
            m_pend = 1'b1;
         end
         if (w && be != 4'd0) begin
            if (a == 2'd0) begin
               tmp    = replace_bytes({28'd0, oc}, d, be);
               m_ctrl = tmp[3:0];
               m_flag = 1'b0;
            end else if (a == 2'd1) begin
               m_preset = replace_bytes(op, d, be);
            end
         end
      end
   endtask

   // One bus cycle: drive inputs, queue the expected response, advance one edge.
   task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                      input logic [3:0] be, input logic [31:0] d, input bit chk);
      logic [31:0] ru;
      ru     = $urandom;
      reset  = r;
      we     = w;
      addr   = {ru[27:0], a};
      byteen = be;
      din    = d;
      drv_e.chk = chk;
      drv_e.a   = a;
      drv_e.d   = m_read(a);
      drv_e.irq = m_flag & m_ctrl[3];
      exp_q.push_back(drv_e);
      @(posedge clk);
      #1;
      model_edge(r, w, a, be, d);
   endtask

   task automatic idle(input logic [1:0] a);
      cyc(1'b0, 1'b0, a, 4'hF, $urandom, 1'b1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
      cyc(1'b0, 1'b1, a, be, d, 1'b1);
   endtask

   // Direct read against a constant; at most three of these between cycles.
   task automatic rd_chk(input logic [1:0] a, input logic [31:0] ed, input logic ei,
                         input string nm);
      we   = 1'b0;
      addr = {28'd0, a};
      #1;
      checks++;
      if (dout !== ed || irq !== ei) begin
         failures++;
         $display("FAIL %s: dout=%h irq=%b, expected dout=%h irq=%b", nm, dout, irq, ed, ei);
      end
   endtask

   task automatic chk_int(input int act, input int ex, input string nm);
      checks++;
      if (act != ex) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, ex);
      end
   endtask

   // Scoreboard monitor, sampling away from the rising edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         if (mon_e.chk) begin
            checks++;
            if (dout !== mon_e.d || irq !== mon_e.irq) begin
               failures++;
               $display("FAIL sb addr=%0d: dout=%h irq=%b, expected dout=%h irq=%b",
                        mon_e.a, dout, irq, mon_e.d, mon_e.irq);
            end
         end
      end
   end

   initial begin
      int cnt_exp [6];
      int first, last, np;
      logic [1:0]  ra;
      logic [3:0]  rbe;
      logic [31:0] rd;
      logic        rr, rw;

      cnt_exp = '{0, 3, 2, 1, 0, 0};

      // Reset held two cycles, then all registers read zero.
      cyc(1'b1, 1'b0, 2'd0, 4'h0, 32'd0, 1'b0);
      cyc(1'b1, 1'b0, 2'd0, 4'h0, 32'd0, 1'b1);
      rd_chk(2'd0, 32'd0, 1'b0, "rst_ctrl");
      rd_chk(2'd1, 32'd0, 1'b0, "rst_preset");
      rd_chk(2'd2, 32'd0, 1'b0, "rst_count");
      idle(2'd3);
      rd_chk(2'd3, 32'd0, 1'b0, "rst_rsvd");

      // One-shot: PRESET=3, CTRL=EN|IM.
      wr(2'd1, 4'hF, 32'd3);
      wr(2'd0, 4'hF, 32'h9);
      for (int k = 0; k < 6; k++) begin
         idle(2'd2);
         rd_chk(2'd2, cnt_exp[k], (k >= 4), "oneshot_count");
      end
      rd_chk(2'd0, 32'h8, 1'b1, "oneshot_ctrl");
      wr(2'd0, 4'hF, 32'h8);
      rd_chk(2'd0, 32'h8, 1'b0, "oneshot_irq_clear");

      // Auto-reload: PRESET=2, CTRL=EN|MODE1|IM, pulses 5 edges apart.
      wr(2'd1, 4'hF, 32'd2);
      wr(2'd0, 4'hF, 32'hB);
      first = -1; last = -1; np = 0;
      for (int k = 1; k <= 20; k++) begin
         idle(2'd0);
         if (irq === 1'b1) begin
            np++;
            if (last < 0) begin
               first = k;
               chk_int(first, 4, "reload_first");
            end else begin
               chk_int(k - last, 5, "reload_period");
            end
            last = k;
         end
      end
      chk_int(np, 4, "reload_pulses");
      wr(2'd0, 4'hF, 32'h0);
      for (int k = 0; k < 3; k++) idle(2'd2);

      // Masked: flag sets internally but irq stays low; EN clears in mode 0.
      wr(2'd1, 4'hF, 32'd4);
      wr(2'd0, 4'hF, 32'h1);
      for (int k = 0; k < 10; k++) begin
         idle(2'd2);
         chk_int(int'(irq), 0, "mask_irq");
      end
      rd_chk(2'd0, 32'h0, 1'b0, "mask_ctrl");

      // Disable mid-count: COUNT freezes at 2.
      wr(2'd0, 4'hF, 32'h9);
      idle(2'd2);
      idle(2'd2);
      idle(2'd2);
      rd_chk(2'd2, 32'd3, 1'b0, "dis_pre");
      wr(2'd0, 4'hF, 32'h8);
      for (int k = 0; k < 6; k++) idle(2'd2);
      rd_chk(2'd2, 32'd2, 1'b0, "dis_freeze");

      // Byte enables, zero byteen, read-only COUNT, reserved slot.
      wr(2'd1, 4'hF, 32'h11223344);
      wr(2'd1, 4'b0101, 32'hAABBCCDD);
      rd_chk(2'd1, 32'h11BB33DD, 1'b0, "byteen_merge");
      wr(2'd1, 4'h0, 32'hFFFFFFFF);
      rd_chk(2'd1, 32'h11BB33DD, 1'b0, "byteen_zero");
      wr(2'd2, 4'hF, 32'h5A5A5A5A);
      rd_chk(2'd2, 32'd2, 1'b0, "count_ro");
      wr(2'd3, 4'hF, 32'hFFFFFFFF);
      rd_chk(2'd3, 32'd0, 1'b0, "rsvd_ro");

      // Collision: CTRL write while in INT (mode 0) keeps EN and reloads.
      wr(2'd1, 4'hF, 32'd1);
      wr(2'd0, 4'hF, 32'h9);
      idle(2'd2);
      idle(2'd2);
      idle(2'd2);
      rd_chk(2'd2, 32'd0, 1'b1, "coll_pre");
      wr(2'd0, 4'hF, 32'h9);
      rd_chk(2'd0, 32'h9, 1'b0, "coll_en_kept");
      idle(2'd2);
      idle(2'd2);
      idle(2'd2);
      chk_int(int'(irq), 1, "coll_reload_irq");
      wr(2'd0, 4'hF, 32'h0);
      idle(2'd2);
      idle(2'd2);

      // Reset while COUNT=5.
      wr(2'd1, 4'hF, 32'd7);
      wr(2'd0, 4'hF, 32'h9);
      for (int k = 0; k < 4; k++) idle(2'd2);
      rd_chk(2'd2, 32'd5, 1'b0, "rst_mid_pre");
      cyc(1'b1, 1'b0, 2'd2, 4'h0, 32'd0, 1'b1);
      rd_chk(2'd0, 32'd0, 1'b0, "rst_mid_ctrl");
      rd_chk(2'd1, 32'd0, 1'b0, "rst_mid_preset");
      rd_chk(2'd2, 32'd0, 1'b0, "rst_mid_count");
      for (int k = 0; k < 12; k++) begin
         idle(2'd2);
         chk_int(int'(irq), 0, "rst_mid_noirq");
      end

      // Random traffic checked through the scoreboard.
      for (int k = 0; k < 1500; k++) begin
         rr  = ($urandom_range(0, 299) == 0);
         rw  = ($urandom_range(0, 3) == 0);
         ra  = 2'($urandom_range(0, 3));
         rbe = 4'($urandom);
         if (ra == 2'd1 && $urandom_range(0, 9) != 0) rd = 32'($urandom_range(0, 8));
         else                                        rd = $urandom;
         cyc(rr, rw, ra, rbe, rd, 1'b1);
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer on the CPU's data-side bus, downstream of the pipeline's M-stage store/load port (byte-enable write, word address, combinational read-back). It is instantiated behind the system bridge. Its `irq` output drives one bit of the CPU's `HWInt[5:0]` input, which is sampled by CP0. It supports one-shot mode (0) and auto-reload mode (1), with a maskable interrupt.

## Interface
- `PRESET_RST`, default 0: reset value of PRESET.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the clock edge.
- `addr`  in  30 (`[31:2]`): word address; only `addr[3:2]` is decoded; the bridge asserts `we` only when the device is selected.
- `we`  in  1: write strobe for this device.
- `byteen`  in  4: byte enables, bit i covers `din[8i+7:8i]`; a write with `byteen==0` is a no-op.
- `din`  in  32: store data (forwarded rt value).
- `dout`  out  32: read data for `addr[3:2]`, combinational.
- `irq`  out  1: interrupt request, equal to `irq_flag & CTRL.IM`.

## Operation
- Register map (`addr[3:2]`):
  - 0: CTRL. Bit 0 = EN, bits [2:1] = MODE, bit 3 = IM. Bits [31:4] are not stored and read 0.
  - 1: PRESET, 32-bit read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reserved; reads 0, writes ignored.
- Writes merge bytewise: `new = (old & ~mask) | (din & mask)`, where mask is built from `byteen`.
- States: IDLE, LOAD, CNT, INT. Two-bit state register.
  - IDLE: if `CTRL.EN` → LOAD.
  - LOAD: `COUNT <= PRESET`, `irq_flag <= 0` → CNT.
  - CNT:
    - If `!CTRL.EN` → IDLE; COUNT holds.
    - Else if `COUNT > 1`: `COUNT <= COUNT-1`.
    - Else (`COUNT` is 0 or 1): `COUNT <= 0`, `irq_flag <= 1` → INT.
  - INT:
    - MODE==1: `irq_flag <= 0` → IDLE. EN stays set, so the timer reloads.
    - Any other MODE (0, 2, 3): `CTRL.EN <= 0` → IDLE; `irq_flag` stays 1.
- `irq_flag` clears on:
  - any CTRL write with a nonzero `byteen`;
  - entry to LOAD;
  - reset.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as the INT-state clearing of EN: the CPU write wins.
  - The FSM acts on the registered CTRL value; a write becomes visible to the FSM one edge later.
- Writing PRESET during CNT does not affect the running COUNT. The new value is used at the next LOAD.
- COUNT is unsigned; there is no wrap below 0.
- Reset values:
  - CTRL = 0, PRESET = `PRESET_RST`, COUNT = 0.
  - State = IDLE, `irq_flag` = 0, `irq` = 0.
  - `dout` reflects the reset register contents.

## Timing
- Read latency is 0: `dout` is valid in the same cycle as `addr` (the M-stage load path).
- Write latency is 1: the register updates on the edge where `we` is sampled.
- Edge E0 writes CTRL with EN=1 and PRESET=N (N≥1). Then:
  - E1: IDLE→LOAD.
  - E2: COUNT=N, CNT.
  - E3…E(N+1): decrement, so COUNT=1 after E(N+1).
  - E(N+2): COUNT=0, `irq_flag`=1, INT.
  - `irq` is first high in the cycle after E(N+2), i.e. N+2 edges after the enable write.
- PRESET=0: COUNT=0 after E2; irq sets at E3.
- Mode 1 period: after the INT edge, the sequence is IDLE, LOAD, CNT, so irq rises every N+3 edges and is high for exactly one cycle.
- Mode 0: `irq` stays high (when IM=1) until the CPU writes CTRL or reset is asserted.
- Reset mid-count: at the reset edge all state returns to reset values; no irq is produced afterwards until re-enabled.

## Test plan
- Reset:
  - Stimulus: hold reset 2 cycles with `PRESET_RST=0`, then read addr 0/1/2/3.
  - Required: `dout` = 0 for every read; `irq`=0.
- One-shot:
  - Stimulus: write PRESET=3, then CTRL=0x9 (EN, MODE 0, IM).
  - Required: COUNT reads 3,2,1,0 on successive cycles. `irq` rises 5 edges after the CTRL write and stays high. CTRL reads 0x8.
  - Then write CTRL=0x8: `irq` drops next cycle.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Required: single-cycle `irq` pulses exactly 5 edges apart for at least 3 periods.
- Mask and disable:
  - Stimulus: CTRL=0x1 with PRESET=4.
  - Required: `irq` stays 0 while `irq_flag` sets internally.
  - Then re-run with CTRL=0x9 and write CTRL=0x8 while COUNT=2: COUNT freezes at 2, no `irq`.
- Byte enables and read-only:
  - Stimulus: PRESET=0x11223344, then write `din=0xAABBCCDD` with `byteen=4'b0101`.
  - Required: PRESET reads 0x11BB33DD.
  - Stimulus: write COUNT.
  - Required: COUNT is unchanged.
- Collision and reset:
  - Stimulus: CTRL write EN=1 in the same cycle the FSM is in INT (mode 0).
  - Required: EN reads 1 afterwards and the timer reloads.
  - Stimulus: assert reset while COUNT=5.
  - Required: all registers return to reset values next edge.
